// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches to
// instruction memory, buffers responses, and flushes on redirects.
module fetch_unit #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [Width-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [Width-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [Width-1:0] inst,
  output logic [Width-1:0] inst_pc,
  output logic             fetch_fault,
  output logic [Width-1:0] fault_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [Width-1:0] r_pc, w_pc_nxt;
  logic             r_fault, w_fault_nxt;
  logic [Width-1:0] r_fault_pc, w_fault_pc_nxt;
  logic [CW-1:0]    r_inflight, w_inflight_nxt;
  logic [CW-1:0]    r_drop, w_drop_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [PW-1:0]    r_wp, w_wp_nxt;
  logic [PW-1:0]    r_rp, w_rp_nxt;
  logic [PW-1:0]    r_qwp, r_qrp;

  logic [Width-1:0] r_data [DEPTH];
  logic [Width-1:0] r_ipc  [DEPTH];
  logic [Width-1:0] r_qpc  [DEPTH];

  logic [CW:0] w_occ;
  logic        w_credit_ok;
  logic        w_req_valid;
  logic        w_req_hs;
  logic        w_rsp;
  logic        w_keep;
  logic        w_inst_valid;
  logic        w_pop;

  // Credit covers both buffered entries and fetches still in flight.
  assign w_occ        = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_credit_ok  = w_occ < (CW + 1)'(DEPTH);
  assign w_req_valid  = !rst && (r_state == ST_RUN) && !redirect_valid && w_credit_ok;
  assign w_req_hs     = w_req_valid && imem_req_ready;
  assign w_rsp        = imem_rsp_valid;
  assign w_keep       = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_inst_valid = !rst && (r_state == ST_RUN) && (r_count != '0);
  assign w_pop        = w_inst_valid && inst_ready && !redirect_valid;

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = w_inst_valid;
  assign inst           = w_inst_valid ? r_data[r_rp] : '0;
  assign inst_pc        = w_inst_valid ? r_ipc[r_rp]  : '0;
  assign fetch_fault    = r_fault;
  assign fault_pc       = r_fault_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    w_drop_nxt     = r_drop;
    w_inflight_nxt = r_inflight + CW'(w_req_hs) - CW'(w_rsp);
    w_count_nxt    = r_count;
    w_wp_nxt       = r_wp;
    w_rp_nxt       = r_rp;
    if (redirect_valid) begin
      w_count_nxt = '0;
      w_wp_nxt    = '0;
      w_rp_nxt    = '0;
      // inflight already includes fetches marked for dropping, so the new
      // drop count is simply whatever remains outstanding after this cycle.
      w_drop_nxt  = r_inflight - CW'(w_rsp);
      if (redirect_pc[1:0] == 2'b00) begin
        w_pc_nxt    = redirect_pc;
        w_state_nxt = ST_RUN;
        w_fault_nxt = 1'b0;
      end else begin
        w_state_nxt    = ST_FAULT;
        w_fault_nxt    = 1'b1;
        w_fault_pc_nxt = redirect_pc;
      end
    end else begin
      if (w_req_hs) w_pc_nxt = r_pc + Width'(4);
      if (w_rsp && (r_drop != '0)) w_drop_nxt = r_drop - 1'b1;
      w_count_nxt = r_count + CW'(w_keep) - CW'(w_pop);
      if (w_keep) w_wp_nxt = f_ptr_inc(r_wp);
      if (w_pop)  w_rp_nxt = f_ptr_inc(r_rp);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_qwp      <= '0;
      r_qrp      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
      r_count    <= w_count_nxt;
      r_wp       <= w_wp_nxt;
      r_rp       <= w_rp_nxt;
      if (w_req_hs) r_qwp <= f_ptr_inc(r_qwp);
      if (w_rsp)    r_qrp <= f_ptr_inc(r_qrp);
    end
  end

  // Request-PC queue tracks every outstanding fetch, dropped or not.
  always_ff @(posedge clk) begin
    if (w_req_hs) r_qpc[r_qwp] <= r_pc;
    if (w_keep) begin
      r_data[r_wp] <= imem_rsp_data;
      r_ipc[r_wp]  <= r_qpc[r_qrp];
    end
  end

endmodule
